// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - arb_state_e : sequencer state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//   - PORT_CORE / PORT_DMA : requester indices (0 = core data port, 1 = DMA/debug)
//   - MEM_LAT_MIN / MEM_LAT_MAX : legal memory latency range
//   - LAT_CNT_W : width of the wait counter, enough for MEM_LAT_MAX
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
// Ports:
//   req0, req1 : requests
//   last_gnt   : index of the port granted most recently
//   winner     : selected port index (meaningful only when valid=1)
//   valid      : at least one request present
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic winner,
  output logic valid
);

  assign valid = req0 | req1;

  // On a conflict the port that was not served last goes next;
  // otherwise the lone requester wins.
  always_comb begin
    winner = PORT_CORE;
    if (req0 && req1) winner = ~last_gnt;
    else if (req1)    winner = PORT_DMA;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core data
// port (port 0) and a DMA/debug loader (port 1). One access in flight at a
// time: IDLE -> ISSUE (1 cycle) -> WAIT (MEM_LAT cycles) -> DONE (1 cycle).
//
// Ports:
//   clk, Reset_n             : clock, asynchronous active-low reset
//   reqX/weX/addrX/wdataX    : port X request (X = 0 core, 1 DMA)
//   gntX                     : one-cycle pulse, request accepted (ISSUE cycle)
//   doneX                    : one-cycle pulse, access complete (DONE cycle)
//   rdataX                   : read data, valid with doneX, held until next read
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory interface
//   busy                     : sequencer not in IDLE
//   state_dbg                : current sequencer state (arb_state_e encoding)
//   cnt_gnt0/cnt_gnt1/cnt_conflict : statistics, only with DMEM_ARB_STATS_EN
//
// Handshake: a requester holds reqX and its we/addr/wdata stable until it
// sees gntX, then may drop or change them. Requests are sampled only in IDLE.
//
// Build option: define DMEM_ARB_STATS_EN to add the statistics counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1   // legal range MEM_LAT_MIN..MEM_LAT_MAX
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        state_dbg
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       cnt_gnt0,
  output logic [31:0]       cnt_gnt1,
  output logic [31:0]       cnt_conflict
`endif
);

  arb_state_e           state_q, state_d;
  logic                 win_q, win_d;
  logic                 last_gnt_q;
  logic                 we_q;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 cap;
  logic                 rd_cap;
  logic                 arb_winner, arb_valid;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .winner   (arb_winner),
    .valid    (arb_valid)
  );

  assign sel_we    = arb_winner ? we1    : we0;
  assign sel_addr  = arb_winner ? addr1  : addr0;
  assign sel_wdata = arb_winner ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    rd_cap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = ISSUE;
          win_d   = arb_winner;
          cap     = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_CNT_W'(MEM_LAT);
      end
      WAIT: begin
        // cnt_q==1 marks the cycle in which mem_rdata is valid.
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d = DONE;
          rd_cap  = ~we_q;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulse outputs are registered from the next-state decode so they line up
  // with the state they belong to without a combinational path from reqX.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      win_q      <= PORT_CORE;
      last_gnt_q <= PORT_DMA;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt0    <= (state_d == ISSUE) && (win_d == PORT_CORE);
      gnt1    <= (state_d == ISSUE) && (win_d == PORT_DMA);
      done0   <= (state_d == DONE)  && (win_d == PORT_CORE);
      done1   <= (state_d == DONE)  && (win_d == PORT_DMA);
      mem_en  <= cap;
      mem_we  <= cap & sel_we;
      if (cap) begin
        last_gnt_q <= arb_winner;
        we_q       <= sel_we;
        mem_addr   <= sel_addr;
        mem_wdata  <= sel_wdata;
      end
      if (rd_cap) begin
        if (win_q == PORT_DMA) rdata1 <= mem_rdata;
        else                   rdata0 <= mem_rdata;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_gnt0     <= '0;
      cnt_gnt1     <= '0;
      cnt_conflict <= '0;
    end else begin
      if (cap && (arb_winner == PORT_CORE)) cnt_gnt0 <= cnt_gnt0 + 32'd1;
      if (cap && (arb_winner == PORT_DMA))  cnt_gnt1 <= cnt_gnt1 + 32'd1;
      if ((state_q == IDLE) && req0 && req1) cnt_conflict <= cnt_conflict + 32'd1;
    end
  end
`endif

endmodule
